bench_resp_misr: RTL and testbench

//   Response compactor that sits directly downstream of the bench_comb circuit under test.
//   It consumes the 64-bit output vectors over a valid/ready handshake.

---
 rtl/bench_resp_misr.sv | 139 +++++++++++++
 tb/tb_bench_resp_misr.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bench_resp_misr.sv
// ---------------------------------------------------------------------------
// bench_resp_misr
//
// Response compactor for the bench_comb circuit under test. Output vectors
// from the CUT arrive over a valid/ready handshake. Each one is folded into a
// Galois-style MISR. When NUM_VECTORS vectors have been accepted, the final
// signature is compared against golden_sig. A mismatch points to a
// trojan-altered response.
//
// State table
//   state  | meaning
//   -------+----------------------------------------------------------------
//   IDLE   | waiting for start; signature/vec_count hold their last values
//   RUN    | accepting vectors; busy=1, resp_ready=1 (unless abort is high)
//   DONE   | run complete; done=1, pass valid, signature held
//
// Ports
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      pulse: begin a run (IDLE or DONE only)
//   abort       in   1      pulse: cancel run / clear result, back to IDLE
//   resp_valid  in   1      response vector valid
//   resp_data   in   WIDTH  response vector
//   resp_ready  out  1      vector is accepted this cycle when resp_valid=1
//   golden_sig  in   WIDTH  expected signature, sampled on the final transfer
//   busy        out  1      run in progress
//   done        out  1      run complete, held until start or abort
//   pass        out  1      final signature matched golden_sig (with done)
//   signature   out  WIDTH  current MISR contents
//   vec_count   out  CNT_W  vectors accepted in the current run
// ---------------------------------------------------------------------------
module bench_resp_misr #(
  parameter int               WIDTH       = 64,
  parameter int               NUM_VECTORS = 1024,
  parameter logic [WIDTH-1:0] POLY        = 64'h0000_0000_0000_001B,
  parameter logic [WIDTH-1:0] SEED        = 64'h0,
  localparam int              CNT_W       = $clog2(NUM_VECTORS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
  output logic             resp_ready,
  input  logic [WIDTH-1:0] golden_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] vec_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] misr_nxt;
  logic             xfer;
  logic             last_xfer;

  // An abort in RUN returns to IDLE with the signature held. Dropping ready
  // in that cycle keeps the handshake honest: no vector is reported as taken
  // and then discarded.
  assign resp_ready = (state == S_RUN) && !abort;
  assign busy       = (state == S_RUN);
  assign done       = (state == S_DONE);

  assign xfer      = resp_valid && resp_ready;
  assign last_xfer = xfer && (vec_count == LAST_IDX);

  // One MISR step: shift left, fold the carried-out MSB back through the
  // feedback taps, then mix in the new response vector.
  always_comb begin
    misr_nxt = {signature[WIDTH-2:0], 1'b0};
    if (signature[WIDTH-1]) begin
      misr_nxt = misr_nxt ^ POLY;
    end
    misr_nxt = misr_nxt ^ resp_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      signature <= SEED;
      vec_count <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Abort has priority, so start is honoured only when abort is low.
          if (start && !abort) begin
            state     <= S_RUN;
            signature <= SEED;
            vec_count <= '0;
            pass      <= 1'b0;
          end
        end

        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
            pass  <= 1'b0;
          end else if (xfer) begin
            signature <= misr_nxt;
            vec_count <= vec_count + CNT_W'(1);
            if (last_xfer) begin
              // golden_sig is used only on this edge. It is compared against
              // the signature that this same edge produces.
              state <= S_DONE;
              pass  <= (misr_nxt == golden_sig);
            end
          end
        end

        S_DONE: begin
          if (abort) begin
            state <= S_IDLE;
            pass  <= 1'b0;
          end else if (start) begin
            state     <= S_RUN;
            signature <= SEED;
            vec_count <= '0;
            pass      <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bench_resp_misr.sv
module tb_bench_resp_misr;

  localparam logic [63:0] POLY   = 64'h0000_0000_0000_001B;
  localparam logic [63:0] SEED_B = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // dut_a: four vectors per run, seed 0
  logic        start_a, abort_a, valid_a, ready_a, busy_a, done_a, pass_a;
  logic [63:0] data_a, golden_a, sig_a;
  logic [2:0]  cnt_a;

  // dut_b: single-vector run, seed with the MSB set
  logic        start_b, abort_b, valid_b, ready_b, busy_b, done_b, pass_b;
  logic [63:0] data_b, golden_b, sig_b;
  logic [0:0]  cnt_b;

  int vectors = 0;
  int errors  = 0;

  bench_resp_misr #(.WIDTH(64), .NUM_VECTORS(4), .POLY(POLY), .SEED(64'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .resp_valid(valid_a), .resp_data(data_a), .resp_ready(ready_a),
    .golden_sig(golden_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a), .vec_count(cnt_a)
  );

  bench_resp_misr #(.WIDTH(64), .NUM_VECTORS(1), .POLY(POLY), .SEED(SEED_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .resp_valid(valid_b), .resp_data(data_b), .resp_ready(ready_b),
    .golden_sig(golden_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b), .vec_count(cnt_b)
  );

  // Reference MISR step: treat the signature as a polynomial, multiply by x,
  // reduce with POLY on overflow, then add the new vector.
  function automatic logic [63:0] misr_ref(input logic [63:0] s, input logic [63:0] d);
    logic [63:0] r;
    r = s << 1;
    if (s[63]) r = r ^ POLY;
    return r ^ d;
  endfunction

  function automatic logic [63:0] run_ref(input logic [63:0] seed, input logic [63:0] dv [4]);
    logic [63:0] s;
    s = seed;
    for (int i = 0; i < 4; i++) s = misr_ref(s, dv[i]);
    return s;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start a run on dut_a and feed four vectors. mode 0 = no stalls,
  // 1 = valid toggles, 2 = random stalls. The task checks every cycle.
  task automatic feed_a(input logic [63:0] dv [4], input int mode,
                        input logic [63:0] golden, input string tag);
    logic [63:0] m_sig;
    int          n;
    logic        v;
    start_a  = 1'b1;
    golden_a = golden;
    tick;
    start_a = 1'b0;
    m_sig = 64'h0;
    n = 0;
    if (busy_a !== 1'b1 || ready_a !== 1'b1 || done_a !== 1'b0 || cnt_a !== 3'd0 || sig_a !== 64'h0) begin
      $display("FAIL %s_start: busy=%b ready=%b done=%b cnt=%0d sig=%h, required 1 1 0 0 0",
               tag, busy_a, ready_a, done_a, cnt_a, sig_a);
      errors++;
    end
    for (int cyc = 0; cyc < 200 && n < 4; cyc++) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      valid_a = v;
      data_a  = v ? dv[n] : {$urandom, $urandom};
      tick;
      if (v) begin
        m_sig = misr_ref(m_sig, dv[n]);
        n++;
        vectors++;
      end
      if (sig_a !== m_sig || cnt_a !== 3'(n)) begin
        $display("FAIL %s_step: sig=%h cnt=%0d, required sig=%h cnt=%0d", tag, sig_a, cnt_a, m_sig, n);
        errors++;
      end
      if (done_a !== (n == 4)) begin
        $display("FAIL %s_done_timing: done=%b after %0d transfers", tag, done_a, n);
        errors++;
      end
    end
    valid_a = 1'b0;
    if (n < 4) begin
      $display("FAIL %s_timeout: only %0d of 4 transfers accepted", tag, n);
      errors++;
    end else if (pass_a !== (m_sig == golden) || busy_a !== 1'b0 || ready_a !== 1'b0) begin
      $display("FAIL %s_result: pass=%b busy=%b ready=%b, required pass=%b busy=0 ready=0",
               tag, pass_a, busy_a, ready_a, (m_sig == golden));
      errors++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    {start_a, abort_a, valid_a, start_b, abort_b, valid_b} = '0;
    data_a = '0; golden_a = '0; data_b = '0; golden_b = '0;
    #22;
    if (sig_a !== 64'h0 || cnt_a !== 3'd0 || busy_a || done_a || pass_a || ready_a) begin
      $display("FAIL reset_a: sig=%h cnt=%0d busy=%b done=%b pass=%b ready=%b, required all 0",
               sig_a, cnt_a, busy_a, done_a, pass_a, ready_a);
      errors++;
    end
    if (sig_b !== SEED_B || cnt_b !== 1'b0 || busy_b || done_b || pass_b || ready_b) begin
      $display("FAIL reset_b: sig=%h cnt=%0d busy=%b done=%b, required sig=%h rest 0",
               sig_b, cnt_b, busy_b, done_b, SEED_B);
      errors++;
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    logic [63:0] dv [4];
    dv = '{64'd1, 64'd0, 64'd0, 64'd0};
    feed_a(dv, 0, 64'h8, "basic");
    if (sig_a !== 64'h8 || pass_a !== 1'b1) begin
      $display("FAIL basic_final: sig=%h pass=%b, required sig=8 pass=1", sig_a, pass_a);
      errors++;
    end
    // A golden_sig change after completion must not disturb the held result.
    golden_a = 64'hDEAD_BEEF;
    tick; tick;
    if (pass_a !== 1'b1 || done_a !== 1'b1 || sig_a !== 64'h8) begin
      $display("FAIL basic_hold: pass=%b done=%b sig=%h, required 1 1 8", pass_a, done_a, sig_a);
      errors++;
    end
  endtask

  task automatic test_feedback;
    start_b = 1'b1; golden_b = 64'h1B;
    tick;
    start_b = 1'b0;
    if (busy_b !== 1'b1 || sig_b !== SEED_B) begin
      $display("FAIL feedback_start: busy=%b sig=%h, required 1 %h", busy_b, sig_b, SEED_B);
      errors++;
    end
    valid_b = 1'b1; data_b = 64'h0;
    tick;
    valid_b = 1'b0;
    vectors++;
    if (sig_b !== 64'h1B || done_b !== 1'b1 || pass_b !== 1'b1 || cnt_b !== 1'b1) begin
      $display("FAIL feedback: sig=%h done=%b pass=%b cnt=%0d, required 1b 1 1 1",
               sig_b, done_b, pass_b, cnt_b);
      errors++;
    end
  endtask

  task automatic test_stall;
    logic [63:0] dv [4];
    dv = '{64'd1, 64'd0, 64'd0, 64'd0};
    feed_a(dv, 1, 64'h8, "stall");
    if (sig_a !== 64'h8 || pass_a !== 1'b1) begin
      $display("FAIL stall_final: sig=%h pass=%b, required 8 1", sig_a, pass_a);
      errors++;
    end
  endtask

  task automatic test_mismatch;
    logic [63:0] dv [4];
    dv = '{64'd1, 64'd0, 64'd0, 64'd1};
    feed_a(dv, 0, 64'h8, "mismatch");
    if (sig_a !== 64'h9 || pass_a !== 1'b0 || done_a !== 1'b1) begin
      $display("FAIL mismatch_final: sig=%h pass=%b done=%b, required 9 0 1", sig_a, pass_a, done_a);
      errors++;
    end
  endtask

  task automatic test_control;
    logic [63:0] s2, fin;
    logic [63:0] dv [4];
    s2 = misr_ref(misr_ref(64'h0, 64'h5), 64'h3);
    start_a = 1'b1; tick; start_a = 1'b0;
    valid_a = 1'b1; data_a = 64'h5; tick;
    data_a = 64'h3; tick;
    valid_a = 1'b0;
    vectors += 2;
    if (cnt_a !== 3'd2 || sig_a !== s2) begin
      $display("FAIL ctrl_two: cnt=%0d sig=%h, required 2 %h", cnt_a, sig_a, s2);
      errors++;
    end
    start_a = 1'b1; tick; start_a = 1'b0;
    if (cnt_a !== 3'd2 || sig_a !== s2 || busy_a !== 1'b1) begin
      $display("FAIL ctrl_start_in_run: cnt=%0d sig=%h busy=%b, required 2 %h 1", cnt_a, sig_a, busy_a, s2);
      errors++;
    end
    abort_a = 1'b1; valid_a = 1'b1; data_a = 64'h7; tick;
    abort_a = 1'b0; valid_a = 1'b0;
    if (busy_a || done_a || pass_a || ready_a || cnt_a !== 3'd2 || sig_a !== s2) begin
      $display("FAIL ctrl_abort_run: busy=%b done=%b pass=%b ready=%b cnt=%0d sig=%h, required 0 0 0 0 2 %h",
               busy_a, done_a, pass_a, ready_a, cnt_a, sig_a, s2);
      errors++;
    end
    abort_a = 1'b1; tick; abort_a = 1'b0;
    valid_a = 1'b1; data_a = 64'h9; tick; valid_a = 1'b0;
    if (busy_a || done_a || cnt_a !== 3'd2 || sig_a !== s2) begin
      $display("FAIL ctrl_idle_inputs: busy=%b done=%b cnt=%0d sig=%h, required 0 0 2 %h",
               busy_a, done_a, cnt_a, sig_a, s2);
      errors++;
    end
    start_a = 1'b1; abort_a = 1'b1; tick;
    start_a = 1'b0; abort_a = 1'b0;
    if (busy_a || done_a || cnt_a !== 3'd2) begin
      $display("FAIL ctrl_start_abort: busy=%b done=%b cnt=%0d, required 0 0 2", busy_a, done_a, cnt_a);
      errors++;
    end
    for (int i = 0; i < 4; i++) dv[i] = {$urandom, $urandom};
    fin = run_ref(64'h0, dv);
    feed_a(dv, 0, fin, "ctrl_run");
    valid_a = 1'b1; data_a = 64'h1234;
    tick; tick; tick;
    valid_a = 1'b0;
    if (cnt_a !== 3'd4 || sig_a !== fin || done_a !== 1'b1 || pass_a !== 1'b1) begin
      $display("FAIL ctrl_done_hold: cnt=%0d sig=%h done=%b pass=%b, required 4 %h 1 1",
               cnt_a, sig_a, done_a, pass_a, fin);
      errors++;
    end
    start_a = 1'b1; tick; start_a = 1'b0;
    if (busy_a !== 1'b1 || done_a || pass_a || cnt_a !== 3'd0 || sig_a !== 64'h0) begin
      $display("FAIL ctrl_restart: busy=%b done=%b pass=%b cnt=%0d sig=%h, required 1 0 0 0 0",
               busy_a, done_a, pass_a, cnt_a, sig_a);
      errors++;
    end
    abort_a = 1'b1; tick; abort_a = 1'b0;
    feed_a(dv, 2, fin, "ctrl_run2");
    abort_a = 1'b1; tick; abort_a = 1'b0;
    if (done_a || pass_a || busy_a || cnt_a !== 3'd4 || sig_a !== fin) begin
      $display("FAIL ctrl_abort_done: done=%b pass=%b busy=%b cnt=%0d sig=%h, required 0 0 0 4 %h",
               done_a, pass_a, busy_a, cnt_a, sig_a, fin);
      errors++;
    end
  endtask

  task automatic test_random;
    logic [63:0] dv [4];
    logic [63:0] fin, gold, d;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) dv[i] = {$urandom, $urandom};
      fin  = run_ref(64'h0, dv);
      gold = ($urandom_range(0, 1) == 1) ? fin : fin ^ (64'h1 << $urandom_range(0, 63));
      feed_a(dv, 2, gold, "random");
    end
    for (int r = 0; r < 4; r++) begin
      d = {$urandom, $urandom};
      start_b = 1'b1; golden_b = misr_ref(SEED_B, d); tick; start_b = 1'b0;
      valid_b = 1'b1; data_b = d; tick; valid_b = 1'b0;
      vectors++;
      if (sig_b !== misr_ref(SEED_B, d) || done_b !== 1'b1 || pass_b !== 1'b1) begin
        $display("FAIL random_b: sig=%h done=%b pass=%b, required %h 1 1",
                 sig_b, done_b, pass_b, misr_ref(SEED_B, d));
        errors++;
      end
    end
  endtask

  task automatic test_reset_midrun;
    start_a = 1'b1; start_b = 1'b1; tick;
    start_a = 1'b0; start_b = 1'b0;
    valid_a = 1'b1; data_a = 64'hFFFF_0000_FFFF_0000; tick; tick;
    valid_a = 1'b0;
    vectors += 2;
    #2;
    rst_n = 1'b0;
    #1;
    if (sig_a !== 64'h0 || cnt_a !== 3'd0 || busy_a || done_a || pass_a || ready_a) begin
      $display("FAIL reset_mid_a: sig=%h cnt=%0d busy=%b done=%b pass=%b ready=%b, required all 0",
               sig_a, cnt_a, busy_a, done_a, pass_a, ready_a);
      errors++;
    end
    if (sig_b !== SEED_B || busy_b || ready_b || done_b) begin
      $display("FAIL reset_mid_b: sig=%h busy=%b ready=%b done=%b, required %h 0 0 0",
               sig_b, busy_b, ready_b, done_b, SEED_B);
      errors++;
    end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_feedback;
    test_stall;
    test_mismatch;
    test_control;
    test_random;
    test_reset_midrun;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
